// File: rtl/sync_pkg.sv
// Shared types and defaults for the PSS transmit framer.
package sync_pkg;

    localparam int cPSS_MAX = 1024;
    localparam int cLEN_W   = 12;

    typedef logic [cLEN_W-1:0] len_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PSS  = 2'd1,
        DATA = 2'd2
    } state_t;

endpackage

// File: rtl/pss_store.sv
// PSS symbol store: {I,Q} flop array filled in load order, read by symbol index.
module pss_store
    import sync_pkg::*;
#(
    parameter int pDAT_Num = cPSS_MAX,
    parameter int pADDR_W  = $clog2(pDAT_Num + 1)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               ival_pss_i,
    input  logic               load_en_i,
    input  logic               ipss_I_i,
    input  logic               ipss_Q_i,
    input  logic [pADDR_W-1:0] rd_addr_i,
    output logic [1:0]         rd_data_o
);

    localparam int                 cIDX_W = $clog2(pDAT_Num);
    localparam logic [pADDR_W-1:0] cDEPTH = pADDR_W'(pDAT_Num);

    logic [1:0]         mem_q [pDAT_Num];
    logic [pADDR_W-1:0] wr_cnt_q;
    logic               we;

    // Writes beyond the store depth or while a frame is in flight are dropped.
    assign we = ival_pss_i && load_en_i && (wr_cnt_q < cDEPTH);

    // Write pointer restarts at 0 whenever the load strobe drops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_cnt_q <= '0;
        end else if (!ival_pss_i) begin
            wr_cnt_q <= '0;
        end else if (we) begin
            wr_cnt_q <= wr_cnt_q + pADDR_W'(1);
        end
    end

    // Symbol array; cleared by reset so an unreloaded frame transmits zeros.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < pDAT_Num; i++) begin
                mem_q[i] <= 2'b00;
            end
        end else if (we) begin
            mem_q[cIDX_W'(wr_cnt_q)] <= {ipss_I_i, ipss_Q_i};
        end
    end

    assign rd_data_o = (rd_addr_i < cDEPTH) ? mem_q[cIDX_W'(rd_addr_i)] : 2'b00;

endmodule

// File: rtl/sync_pss_tx.sv
// Transmit framer: PSS preamble from the store, then payload symbols pulled from upstream.
module sync_pss_tx
    import sync_pkg::*;
#(
    parameter int pDAT_Num = cPSS_MAX,
    parameter int pLEN_W   = cLEN_W
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              iena,
    input  logic [pLEN_W-1:0] corr_size,
    input  logic [pLEN_W-1:0] frame_len,
    input  logic              ival_pss,
    input  logic              ipss_I,
    input  logic              ipss_Q,
    input  logic              istart,
    input  logic              idata_val,
    input  logic              idata_I,
    input  logic              idata_Q,
    output logic              odata_rdy,
    output logic              oval,
    output logic              odata_I,
    output logic              odata_Q,
    output logic              osop,
    output logic              oeop,
    output logic              obusy,
    output logic              ounderrun
);

    localparam int                cADDR_W = $clog2(pDAT_Num + 1);
    localparam logic [pLEN_W-1:0] cCAP    = pLEN_W'(pDAT_Num);

    state_t            state_q, state_d;
    logic [pLEN_W-1:0] cnt_q, cnt_d;
    logic [pLEN_W-1:0] eff_q, eff_d;
    logic [pLEN_W-1:0] flen_q, flen_d;
    logic              oval_q, oval_d;
    logic              oi_q, oi_d;
    logic              oq_q, oq_d;
    logic              osop_q, osop_d;
    logic              oeop_q, oeop_d;
    logic              ound_q, ound_d;
    logic [pLEN_W-1:0] eff_pss;
    logic [1:0]        pss_sym;

    // A PSS longer than the store is clipped to the store depth.
    assign eff_pss = (corr_size > cCAP) ? cCAP : corr_size;

    pss_store #(
        .pDAT_Num (pDAT_Num),
        .pADDR_W  (cADDR_W)
    ) u_store (
        .clk_i      (iclk),
        .rst_n_i    (ireset),
        .ival_pss_i (ival_pss),
        .load_en_i  (state_q == IDLE),
        .ipss_I_i   (ipss_I),
        .ipss_Q_i   (ipss_Q),
        .rd_addr_i  (cADDR_W'(cnt_q)),
        .rd_data_o  (pss_sym)
    );

    // Next-state, counters and next output symbol; one symbol per iena.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        eff_d     = eff_q;
        flen_d    = flen_q;
        oval_d    = 1'b0;
        oi_d      = 1'b0;
        oq_d      = 1'b0;
        osop_d    = 1'b0;
        oeop_d    = 1'b0;
        ound_d    = 1'b0;
        odata_rdy = 1'b0;
        case (state_q)
            IDLE: begin
                if (istart && (eff_pss != '0 || frame_len != '0)) begin
                    state_d = (eff_pss != '0) ? PSS : DATA;
                    cnt_d   = '0;
                    eff_d   = eff_pss;
                    flen_d  = frame_len;
                end
            end
            PSS: begin
                if (iena) begin
                    oval_d       = 1'b1;
                    {oi_d, oq_d} = pss_sym;
                    osop_d       = (cnt_q == '0);
                    if (cnt_q == eff_q - pLEN_W'(1)) begin
                        cnt_d = '0;
                        if (flen_q == '0) begin
                            oeop_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + pLEN_W'(1);
                    end
                end
            end
            DATA: begin
                if (iena) begin
                    odata_rdy = 1'b1;
                    oval_d    = 1'b1;
                    if (idata_val) begin
                        {oi_d, oq_d} = {idata_I, idata_Q};
                    end else begin
                        ound_d = 1'b1;
                    end
                    osop_d = (cnt_q == '0) && (eff_q == '0);
                    if (cnt_q == flen_q - pLEN_W'(1)) begin
                        oeop_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + pLEN_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, latched lengths and registered output symbol.
    always_ff @(posedge iclk or negedge ireset) begin
        if (!ireset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            eff_q   <= '0;
            flen_q  <= '0;
            oval_q  <= 1'b0;
            oi_q    <= 1'b0;
            oq_q    <= 1'b0;
            osop_q  <= 1'b0;
            oeop_q  <= 1'b0;
            ound_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eff_q   <= eff_d;
            flen_q  <= flen_d;
            oval_q  <= oval_d;
            oi_q    <= oi_d;
            oq_q    <= oq_d;
            osop_q  <= osop_d;
            oeop_q  <= oeop_d;
            ound_q  <= ound_d;
        end
    end

    assign oval      = oval_q;
    assign odata_I   = oi_q;
    assign odata_Q   = oq_q;
    assign osop      = osop_q;
    assign oeop      = oeop_q;
    assign ounderrun = ound_q;
    assign obusy     = (state_q != IDLE);

endmodule
